// File: rtl/traffic_controller_nway.sv
// N-way round-robin traffic light controller with prescaled phase timing.
// Optional emergency pre-emption is enabled by defining TRAFFIC_EMERGENCY_PREEMPT_EN.
module traffic_controller_nway #(
    parameter int N_DIR         = 4,
    parameter int CLK_DIV       = 100000000,
    parameter int GREEN_TICKS   = 10,
    parameter int YELLOW_TICKS  = 3,
    parameter int ALL_RED_TICKS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
    input  logic [N_DIR-1:0]     emerg_req,
`endif
    input  logic [N_DIR-1:0]     car_present,
    output logic [3*N_DIR-1:0]   lights,
    output logic                 tick,
    output logic [2:0]           active_dir,
    output logic [1:0]           phase,
    output logic [7:0]           ticks_left
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_PRE  = PW'(CLK_DIV - 2);
    localparam logic [7:0] G_LEN = 8'(GREEN_TICKS - 1);
    localparam logic [7:0] Y_LEN = 8'(YELLOW_TICKS - 1);
    localparam logic [7:0] A_LEN = 8'(ALL_RED_TICKS - 1);

    typedef enum logic [1:0] {
        ALL_RED = 2'b00,
        GREEN   = 2'b01,
        YELLOW  = 2'b10
    } phase_e;

    logic [PW-1:0]      r_presc;
    logic               r_tick;
    phase_e             r_phase;
    logic [7:0]         r_ticks;
    logic [2:0]         r_active;
    logic [2:0]         r_next;
    logic [3*N_DIR-1:0] r_lights;

    logic               w_rr_found;
    logic [2:0]         w_rr_dir;
    int                 w_best;
    int                 w_dist;
    logic               w_em_any;
    logic [2:0]         w_em_dir;
    logic [2:0]         w_grant;

    // Nearest requesting direction after the active one, by forward distance.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_dir   = r_active;
        w_best     = N_DIR;
        w_dist     = 0;
        for (int i = 0; i < N_DIR; i++) begin
            w_dist = (i - int'(r_active) + N_DIR) % N_DIR;
            if (car_present[i] && w_dist != 0 && w_dist < w_best) begin
                w_best     = w_dist;
                w_rr_found = 1'b1;
                w_rr_dir   = 3'(i);
            end
        end
    end

`ifdef TRAFFIC_EMERGENCY_PREEMPT_EN
    always_comb begin
        w_em_any = |emerg_req;
        w_em_dir = 3'd0;
        for (int i = N_DIR - 1; i >= 0; i--) begin
            if (emerg_req[i]) w_em_dir = 3'(i);
        end
    end
`else
    assign w_em_any = 1'b0;
    assign w_em_dir = 3'd0;
`endif

    assign w_grant = w_em_any ? w_em_dir : r_next;

    function automatic logic [3*N_DIR-1:0] f_lights(
        input phase_e     p,
        input logic [2:0] d
    );
        logic [3*N_DIR-1:0] v;
        v = '0;
        for (int i = 0; i < N_DIR; i++) begin
            v[3*i +: 3] = 3'b100;
            if (3'(i) == d && p == GREEN)  v[3*i +: 3] = 3'b001;
            if (3'(i) == d && p == YELLOW) v[3*i +: 3] = 3'b010;
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc  <= '0;
            r_tick   <= 1'b0;
            r_phase  <= ALL_RED;
            r_ticks  <= A_LEN;
            r_active <= 3'd0;
            r_next   <= 3'd0;
            r_lights <= f_lights(ALL_RED, 3'd0);
        end else begin
            r_presc <= (r_presc == P_LAST) ? '0 : r_presc + 1'b1;
            r_tick  <= (r_presc == P_PRE);
            if (r_tick) begin
                unique case (r_phase)
                    GREEN: begin
                        if (w_em_any && w_em_dir != r_active) begin
                            r_phase  <= YELLOW;
                            r_ticks  <= Y_LEN;
                            r_next   <= w_em_dir;
                            r_lights <= f_lights(YELLOW, r_active);
                        end else if (w_em_any) begin
                            r_ticks <= G_LEN;
                        end else if (r_ticks != 8'd0) begin
                            r_ticks <= r_ticks - 8'd1;
                        end else if (w_rr_found) begin
                            r_phase  <= YELLOW;
                            r_ticks  <= Y_LEN;
                            r_next   <= w_rr_dir;
                            r_lights <= f_lights(YELLOW, r_active);
                        end else begin
                            r_ticks <= G_LEN;
                        end
                    end
                    YELLOW: begin
                        if (w_em_any) r_next <= w_em_dir;
                        if (r_ticks != 8'd0) begin
                            r_ticks <= r_ticks - 8'd1;
                        end else begin
                            r_phase  <= ALL_RED;
                            r_ticks  <= A_LEN;
                            r_lights <= f_lights(ALL_RED, r_active);
                        end
                    end
                    ALL_RED: begin
                        if (r_ticks != 8'd0) begin
                            r_ticks <= r_ticks - 8'd1;
                            if (w_em_any) r_next <= w_em_dir;
                        end else begin
                            r_phase  <= GREEN;
                            r_ticks  <= G_LEN;
                            r_active <= w_grant;
                            r_next   <= w_grant;
                            r_lights <= f_lights(GREEN, w_grant);
                        end
                    end
                    default: begin
                        r_phase  <= ALL_RED;
                        r_ticks  <= A_LEN;
                        r_lights <= f_lights(ALL_RED, r_active);
                    end
                endcase
            end
        end
    end

    assign lights     = r_lights;
    assign tick       = r_tick;
    assign active_dir = r_active;
    assign phase      = r_phase;
    assign ticks_left = r_ticks;

endmodule

// File: doc/traffic_controller_nway.md
TRAFFIC_CONTROLLER_NWAY -- requirements
Module: traffic_controller_nway

Interface
REQ-001 Parameter N_DIR, default 4: number of approach directions, legal range 2..8.
REQ-002 Parameter CLK_DIV, default 100000000: clk cycles per timing tick, minimum 2.
REQ-003 Parameter GREEN_TICKS, default 10: green phase length in ticks, minimum 1.
REQ-004 Parameter YELLOW_TICKS, default 3: yellow phase length in ticks, minimum 1.
REQ-005 Parameter ALL_RED_TICKS, default 1: all-red clearance length in ticks, minimum 1.
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port car_present, input, N_DIR: bit i high means demand on direction i.
REQ-009 Port lights, output, 3*N_DIR: direction i occupies bits [3i+2:3i], coded {red,yellow,green}: 100 red, 010 yellow, 001 green; no other codes are legal.
REQ-010 Port tick, output, 1: one-cycle timing pulse.
REQ-011 Port active_dir, output, 3: index of the direction currently or last granted green.
REQ-012 Port phase, output, 2: 00 ALL_RED, 01 GREEN, 10 YELLOW; 11 is never driven.
REQ-013 Port ticks_left, output, 8: remaining ticks in the current phase, minus 1.

Function
REQ-014 The prescaler counts 0..CLK_DIV-1 and wraps; tick is high exactly while prescaler==CLK_DIV-1.
REQ-015 Phase and counter updates occur only on edges where tick=1; between ticks all outputs hold.
REQ-016 The FSM cycles ALL_RED -> GREEN -> YELLOW -> ALL_RED; each phase reloads ticks_left to its length-1 on entry and decrements per tick.
REQ-017 A phase ends on the tick where ticks_left==0.
REQ-018 In GREEN, only active_dir shows 001; in YELLOW, only active_dir shows 010; all other directions, and every direction in ALL_RED, show 100.
REQ-019 At GREEN expiry, next_dir is the first i with car_present[i]=1, searched round-robin from active_dir+1 with wrap at N_DIR-1 to 0, excluding active_dir.
REQ-020 If no other direction has demand at GREEN expiry, GREEN extends: ticks_left reloads to GREEN_TICKS-1 and the FSM does not enter YELLOW.
REQ-021 At ALL_RED expiry, active_dir takes next_dir and GREEN is entered.
REQ-022 car_present is sampled only at GREEN expiry; changes at other times have no effect.
REQ-023 Two directions are never non-red in the same cycle.

Reset
REQ-024 While reset=1 on an edge: prescaler=0, tick=0, phase=ALL_RED, ticks_left=ALL_RED_TICKS-1, active_dir=0, next_dir=0, all lights=100.
REQ-025 Reset asserted mid-phase aborts that phase at once, with no yellow, and takes priority over tick and emergency inputs.

Configuration
REQ-026 Macro TRAFFIC_EMERGENCY_PREEMPT_EN, when defined, adds input port emerg_req, N_DIR wide; the lowest set bit selects emergency direction E.
REQ-027 With the macro defined and phase GREEN on a direction other than E, the next tick forces YELLOW regardless of ticks_left; ALL_RED follows; then E is granted.
REQ-028 With the macro defined, an emergency overrides next_dir to E while in YELLOW or ALL_RED; phase lengths are unchanged.
REQ-029 With the macro defined, GREEN on E does not expire while emerg_req[E]=1; ticks_left holds at GREEN_TICKS-1; normal operation resumes after the request drops.
REQ-030 Without the macro, the port is absent and behaviour is identical to emerg_req held at 0.

Verification (N_DIR=4, CLK_DIV=4, GREEN=5, YELLOW=2, ALL_RED=1)
REQ-031 Release reset, car_present=1111 -> first tick 4 clk later; dir0 green for 20 clk, yellow 8 clk, all-red 4 clk; then dir1, dir2, dir3, dir0 in turn.
REQ-032 car_present=0101 -> grant order 0,2,0,2; dirs 1 and 3 stay 100 throughout.
REQ-033 car_present=0001 -> dir0 green is held indefinitely, ticks_left reloads to 4 at every expiry, and YELLOW never occurs.
REQ-034 Assert reset for 1 cycle during dir2 yellow -> next cycle all lights 100, phase=00, active_dir=0, tick low.
REQ-035 With the macro defined, dir0 green at ticks_left=3, emerg_req=1000 -> yellow at the next tick, then all-red, then dir3 green held until emerg_req=0.
REQ-036 Run 10^5 cycles with random car_present -> lights only ever show legal codes and at most one direction is non-red in any cycle.
